// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and performance-counter selector.
// Consumed by perf_counters and perf_counter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int PERF_NUM_CTRS = 8;

    typedef enum logic [2:0] {
        PERF_ICACHE_HIT    = 3'd0,
        PERF_ICACHE_MISS   = 3'd1,
        PERF_DCACHE_HIT    = 3'd2,
        PERF_DCACHE_MISS   = 3'd3,
        PERF_L2_HIT        = 3'd4,
        PERF_L2_MISS       = 3'd5,
        PERF_BR            = 3'd6,
        PERF_BR_MISPREDICT = 3'd7
    } perf_ctr_sel_t;

    function automatic logic [PERF_NUM_CTRS-1:0] perf_sel_onehot(input perf_ctr_sel_t sel);
        logic [PERF_NUM_CTRS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single 16-bit event counter with synchronous clear and count gate.
// Define PERF_SATURATE_EN to hold at 16'hFFFF instead of wrapping to zero.
module perf_counter
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     inc,
    input  logic     clr,
    output lc3b_word count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            // a clear wins over a coincident event
            count <= '0;
        end else if (en && inc) begin
`ifdef PERF_SATURATE_EN
            if (count != 16'hFFFF)
                count <= count + 16'd1;
`else
            count <= count + 16'd1;
`endif
        end
    end

endmodule

// File: rtl/perf_counters.sv
// Eight live event counters with a snapshot shadow bank; outputs show shadows only.
// Wrap vs. saturate at 16'hFFFF is selected by PERF_SATURATE_EN (in perf_counter).
module perf_counters
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          count_en,
    input  logic          br_event,
    input  logic          br_mispredict,
    input  logic          icache_hit,
    input  logic          icache_miss,
    input  logic          dcache_hit,
    input  logic          dcache_miss,
    input  logic          l2_hit,
    input  logic          l2_miss,
    input  logic          clear_req,
    input  logic          clear_all,
    input  perf_ctr_sel_t clear_sel,
    input  logic          snap_req,
    output logic          snap_ack,
    output lc3b_word      icache_hit_count,
    output lc3b_word      icache_miss_count,
    output lc3b_word      dcache_hit_count,
    output lc3b_word      dcache_miss_count,
    output lc3b_word      l2_hit_count,
    output lc3b_word      l2_miss_count,
    output lc3b_word      br_count,
    output lc3b_word      br_mispredict_count
);

    logic [PERF_NUM_CTRS-1:0] events;
    logic [PERF_NUM_CTRS-1:0] clr_vec;
    lc3b_word                 live   [PERF_NUM_CTRS];
    lc3b_word                 shadow [PERF_NUM_CTRS];

    always_comb begin
        events                     = '0;
        events[PERF_ICACHE_HIT]    = icache_hit;
        events[PERF_ICACHE_MISS]   = icache_miss;
        events[PERF_DCACHE_HIT]    = dcache_hit;
        events[PERF_DCACHE_MISS]   = dcache_miss;
        events[PERF_L2_HIT]        = l2_hit;
        events[PERF_L2_MISS]       = l2_miss;
        events[PERF_BR]            = br_event;
        events[PERF_BR_MISPREDICT] = br_mispredict;
    end

    // clear_all dominates any single-counter clear
    always_comb begin
        clr_vec = '0;
        if (clear_all)
            clr_vec = '1;
        else if (clear_req)
            clr_vec = perf_sel_onehot(clear_sel);
    end

    for (genvar i = 0; i < PERF_NUM_CTRS; i++) begin : g_ctr
        perf_counter u_ctr (
            .clk   (clk),
            .rst   (rst),
            .en    (count_en),
            .inc   (events[i]),
            .clr   (clr_vec[i]),
            .count (live[i])
        );
    end

    // shadows sample the pre-edge live values, so captures see pre-increment/pre-clear state
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_ack <= 1'b0;
            for (int i = 0; i < PERF_NUM_CTRS; i++)
                shadow[i] <= '0;
        end else begin
            snap_ack <= snap_req;
            if (snap_req) begin
                for (int i = 0; i < PERF_NUM_CTRS; i++)
                    shadow[i] <= live[i];
            end
        end
    end

    assign icache_hit_count    = shadow[PERF_ICACHE_HIT];
    assign icache_miss_count   = shadow[PERF_ICACHE_MISS];
    assign dcache_hit_count    = shadow[PERF_DCACHE_HIT];
    assign dcache_miss_count   = shadow[PERF_DCACHE_MISS];
    assign l2_hit_count        = shadow[PERF_L2_HIT];
    assign l2_miss_count       = shadow[PERF_L2_MISS];
    assign br_count            = shadow[PERF_BR];
    assign br_mispredict_count = shadow[PERF_BR_MISPREDICT];

endmodule

// File: tb/tb_perf_counters.sv
// Directed self-checking bench for perf_counters (wrap or saturate per PERF_SATURATE_EN).
module tb_perf_counters;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst, count_en;
    logic          br_event, br_mispredict, icache_hit, icache_miss;
    logic          dcache_hit, dcache_miss, l2_hit, l2_miss;
    logic          clear_req, clear_all, snap_req, snap_ack;
    perf_ctr_sel_t clear_sel;
    lc3b_word      icache_hit_count, icache_miss_count, dcache_hit_count, dcache_miss_count;
    lc3b_word      l2_hit_count, l2_miss_count, br_count, br_mispredict_count;
    lc3b_word      outs [8];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    perf_counters dut (
        .clk                 (clk),
        .rst                 (rst),
        .count_en            (count_en),
        .br_event            (br_event),
        .br_mispredict       (br_mispredict),
        .icache_hit          (icache_hit),
        .icache_miss         (icache_miss),
        .dcache_hit          (dcache_hit),
        .dcache_miss         (dcache_miss),
        .l2_hit              (l2_hit),
        .l2_miss             (l2_miss),
        .clear_req           (clear_req),
        .clear_all           (clear_all),
        .clear_sel           (clear_sel),
        .snap_req            (snap_req),
        .snap_ack            (snap_ack),
        .icache_hit_count    (icache_hit_count),
        .icache_miss_count   (icache_miss_count),
        .dcache_hit_count    (dcache_hit_count),
        .dcache_miss_count   (dcache_miss_count),
        .l2_hit_count        (l2_hit_count),
        .l2_miss_count       (l2_miss_count),
        .br_count            (br_count),
        .br_mispredict_count (br_mispredict_count)
    );

    assign outs[0] = icache_hit_count;
    assign outs[1] = icache_miss_count;
    assign outs[2] = dcache_hit_count;
    assign outs[3] = dcache_miss_count;
    assign outs[4] = l2_hit_count;
    assign outs[5] = l2_miss_count;
    assign outs[6] = br_count;
    assign outs[7] = br_mispredict_count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s[%0d]", tag, i), outs[i], exp);
    endtask

    task automatic set_events(input logic v);
        {br_event, br_mispredict, icache_hit, icache_miss} = {4{v}};
        {dcache_hit, dcache_miss, l2_hit, l2_miss}         = {4{v}};
    endtask

    initial begin
        rst = 1'b1; count_en = 1'b0; set_events(1'b0);
        clear_req = 1'b0; clear_all = 1'b0; clear_sel = PERF_ICACHE_HIT; snap_req = 1'b0;
        step(); step();
        rst = 1'b0;
        check_all("reset_out", 16'h0);
        check("reset_ack", {15'b0, snap_ack}, 16'h0);

        // five icache hits then a snapshot
        count_en = 1'b1;
        icache_hit = 1'b1;
        repeat (5) step();
        icache_hit = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check("ack_after_snap", {15'b0, snap_ack}, 16'h1);
        check("icache_hit_5", icache_hit_count, 16'd5);
        for (int i = 1; i < 8; i++)
            check($sformatf("others_zero[%0d]", i), outs[i], 16'h0);
        step();
        check("ack_one_cycle", {15'b0, snap_ack}, 16'h0);

        // dcache_miss for 10 cycles, gated off on cycles 4..6
        dcache_miss = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            count_en = !(c >= 4 && c <= 6);
            step();
        end
        dcache_miss = 1'b0; count_en = 1'b1;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check("dcache_miss_7", dcache_miss_count, 16'd7);
        check("icache_hit_kept", icache_hit_count, 16'd5);

        // clear_req + event + snap on same edge: snap sees pre-clear value
        l2_miss = 1'b1; repeat (3) step();
        clear_req = 1'b1; clear_sel = PERF_L2_MISS; snap_req = 1'b1; step();
        clear_req = 1'b0; l2_miss = 1'b0;
        check("l2_miss_pre_clear", l2_miss_count, 16'd3);
        step(); snap_req = 1'b0;
        check("l2_miss_cleared", l2_miss_count, 16'd0);
        check("dcache_miss_untouched", dcache_miss_count, 16'd7);

        // clear_all + clear_req with all events, then one event each
        set_events(1'b1);
        clear_all = 1'b1; clear_req = 1'b1; clear_sel = PERF_ICACHE_HIT; step();
        clear_all = 1'b0; clear_req = 1'b0; step();
        set_events(1'b0);
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check_all("after_clear_all", 16'd1);

        // held snap_req: one capture and one ack per cycle
        icache_hit = 1'b1; snap_req = 1'b1;
        step(); check("held_snap1", icache_hit_count, 16'd1); check("held_ack1", {15'b0, snap_ack}, 16'h1);
        step(); check("held_snap2", icache_hit_count, 16'd2); check("held_ack2", {15'b0, snap_ack}, 16'h1);
        step(); check("held_snap3", icache_hit_count, 16'd3); check("held_ack3", {15'b0, snap_ack}, 16'h1);
        icache_hit = 1'b0; snap_req = 1'b0; step();
        check("held_ack_end", {15'b0, snap_ack}, 16'h0);

        // br counter: clear, count to FFFE, then cross the top
        clear_req = 1'b1; clear_sel = PERF_BR; step(); clear_req = 1'b0;
        br_event = 1'b1; repeat (65534) step(); br_event = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check("br_fffe", br_count, 16'hFFFE);
        br_event = 1'b1; step(); br_event = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check("br_ffff", br_count, 16'hFFFF);
        br_event = 1'b1; repeat (2) step(); br_event = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
`ifdef PERF_SATURATE_EN
        check("br_top", br_count, 16'hFFFF);
`else
        check("br_top", br_count, 16'h0001);
`endif

        // count_en low holds the counter
        count_en = 1'b0; icache_miss = 1'b1; repeat (4) step(); icache_miss = 1'b0; count_en = 1'b1;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check("gated_hold", icache_miss_count, 16'd1);

        // rst overrides snap_req and events
        set_events(1'b1); snap_req = 1'b1; clear_req = 1'b1; rst = 1'b1; step();
        set_events(1'b0); snap_req = 1'b0; clear_req = 1'b0; rst = 1'b0;
        check_all("rst_override", 16'h0);
        check("rst_no_ack", {15'b0, snap_ack}, 16'h0);
        step();
        check("rst_no_late_ack", {15'b0, snap_ack}, 16'h0);
        snap_req = 1'b1; step(); snap_req = 1'b0;
        check_all("rst_live_zero", 16'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/perf_counters.md
PERF_COUNTERS -- requirements
Module: perf_counters

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as follows: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these 1-bit inputs: count_en (global count gate), br_event, br_mispredict, icache_hit, icache_miss, dcache_hit, dcache_miss, l2_hit, l2_miss (event strobes, one count per asserted cycle).
REQ-003 The block SHALL have these clear inputs: clear_req  in  1  pulse clearing one counter; clear_all  in  1  pulse clearing all counters; clear_sel  in  3 (perf_ctr_sel_t)  target counter for clear_req.
REQ-004 The block SHALL have these snapshot ports: snap_req  in  1  pulse requesting a shadow capture; snap_ack  out  1  one-cycle pulse when the capture completes.
REQ-005 The block SHALL have these 16-bit (lc3b_word) outputs, each a shadow value feeding the MMIO read decoder: icache_hit_count, icache_miss_count, dcache_hit_count, dcache_miss_count, l2_hit_count, l2_miss_count, br_count, br_mispredict_count.

Function
REQ-006 The block SHALL hold eight 16-bit live counters, indexed by perf_ctr_sel_t: 0 icache_hit, 1 icache_miss, 2 dcache_hit, 3 dcache_miss, 4 l2_hit, 5 l2_miss, 6 br, 7 br_mispredict.
REQ-007 A live counter SHALL increment by exactly 1 on a clock edge where its event strobe=1 and count_en=1; with count_en=0 it SHALL hold.
REQ-008 Independent counters with simultaneous events SHALL all increment on the same edge.
REQ-009 When clear_all=1, every live counter SHALL load 0 on that edge; a coincident event SHALL be discarded (result 0, not 1).
REQ-010 When clear_req=1, only the counter selected by clear_sel SHALL load 0, with a coincident event on it discarded; the other counters SHALL behave normally.
REQ-011 When clear_all and clear_req are asserted together, clear_all SHALL take effect.
REQ-012 Outputs SHALL show only shadow registers; live counters SHALL never drive outputs directly.
REQ-013 When snap_req=1 on edge N, all eight shadows SHALL load the live values as they stood before edge N (pre-increment, pre-clear), and snap_ack SHALL be 1 for the cycle after edge N.
REQ-014 snap_req held high for k cycles SHALL capture on each of those k edges and produce k ack cycles; no request queuing SHALL occur.
REQ-015 Wrap/saturation at 16'hFFFF SHALL follow REQ-019.
REQ-016 The block SHALL be purely synchronous; no output SHALL depend combinationally on any input.

Reset
REQ-017 When rst=1 on an edge, all live counters, all shadows and snap_ack SHALL be 0 after that edge; rst SHALL override clears, events and snap_req in the same cycle.
REQ-018 A snap_req coincident with rst SHALL be dropped; no snap_ack SHALL follow.

Configuration
REQ-019 With PERF_SATURATE_EN defined, a counter at 16'hFFFF SHALL hold at 16'hFFFF on further events; without it, it SHALL wrap to 16'h0000.
REQ-020 No other behaviour SHALL depend on PERF_SATURATE_EN.

Structure
REQ-021 perf_ctr_sel_t (3-bit enum, values per REQ-006) and PERF_NUM_CTRS=8 SHALL reside in lc3b_types; lc3b_word SHALL be reused for counter width.
REQ-022 A sub-module perf_counter (one 16-bit counter: inc, clr, en inputs, honouring PERF_SATURATE_EN) SHALL be instantiated eight times; shadow/snapshot logic SHALL stay in perf_counters.

Verification
REQ-023 Reset, then 5 icache_hit pulses with count_en=1, then snap_req -> icache_hit_count=5 and snap_ack=1 on the following cycle; all other outputs 0.
REQ-024 dcache_miss=1 held 10 cycles with count_en=0 for cycles 4-6, then snap -> dcache_miss_count=7.
REQ-025 Live l2_miss=3; assert clear_req (sel=5), l2_miss and snap_req on the same edge -> shadow l2_miss_count=3; next snap -> 0.
REQ-026 Preload br counter to 16'hFFFE and give 3 br_event -> snapshot 16'hFFFF with PERF_SATURATE_EN defined, 16'h0001 without it.
REQ-027 clear_all and clear_req (sel=0) asserted with all eight events -> all counters 0; next-cycle events then snap -> all counters 1.
REQ-028 rst asserted together with snap_req and events -> all outputs 0, no snap_ack in the following cycle.
